// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial pattern detector:
// FSM state encoding and the length-masked pattern compare.
package seq_det_pkg;

    // Widest pattern the compare helper supports; MAX_LEN must not exceed it.
    localparam int CMP_W = 32;
    localparam int CMP_LEN_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // True when the low 'len' bits of hist and pat agree; bits at and above
    // len are ignored. Callers zero-extend their operands to CMP_W bits.
    function automatic logic masked_eq(
        input logic [CMP_W-1:0]     hist,
        input logic [CMP_W-1:0]     pat,
        input logic [CMP_LEN_W-1:0] len
    );
        logic [CMP_W-1:0] mask;
        if (len >= CMP_LEN_W'(CMP_W)) begin
            mask = '1;
        end else begin
            mask = (CMP_W'(1) << len) - CMP_W'(1);
        end
        return ((hist ^ pat) & mask) == '0;
    endfunction

endpackage

// File: rtl/seq_det_counter.sv
// Saturating match counter with a synchronous clear that outranks increment.
module seq_det_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over a same-cycle increment; hold at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Programmable serial bit-pattern detector. A runtime-loaded pattern of
// 1..MAX_LEN bits is compared against a shift history of accepted bits;
// a hit produces a registered one-cycle match pulse and bumps a saturating
// match counter. Overlap mode decides whether history restarts after a hit.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no pattern loaded (or length 0); din ignored
// FILL    | fewer than len bits accepted since load or last non-overlap hit
// RUN     | history holds at least len bits; every accepted bit is compared
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [1:0]         state
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               match_q, match_d;

    logic [LEN_W-1:0]   len_clamped;
    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   fill_n;
    logic               accept;
    logic               hit_raw;
    logic               hit;

    logic [CMP_W-1:0]     hist_ext;
    logic [CMP_W-1:0]     pat_ext;
    logic [CMP_LEN_W-1:0] len_ext;

    // Lengths beyond the history depth are treated as the full depth.
    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len > LEN_W'(MAX_LEN)) begin
            len_clamped = LEN_W'(MAX_LEN);
        end
    end

    // Candidate history/fill for an accepted bit and the resulting compare.
    // fill_inc carries an extra bit so fill+1 cannot wrap before the min().
    always_comb begin
        hist_n   = (hist_q << 1) | MAX_LEN'(din);
        fill_inc = {1'b0, fill_q} + (LEN_W + 1)'(1);
        fill_n   = fill_inc[LEN_W-1:0];
        if (fill_inc >= {1'b0, len_q}) begin
            fill_n = len_q;
        end
        hist_ext = '0;
        hist_ext[MAX_LEN-1:0] = hist_n;
        pat_ext = '0;
        pat_ext[MAX_LEN-1:0] = pat_q;
        len_ext = '0;
        len_ext[LEN_W-1:0] = len_q;
        hit_raw = (fill_n == len_q) && masked_eq(hist_ext, pat_ext, len_ext);
    end

    // A bit is only taken when valid, a pattern is armed and no reload is
    // happening; a reload in the same cycle discards the bit.
    assign accept = din_valid && !cfg_we && (state_q != ST_IDLE);
    assign hit    = accept && hit_raw;

    // Next-state logic: configuration load, bit acceptance and match pulse.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        match_d = 1'b0;

        if (cfg_we) begin
            pat_d   = cfg_pattern;
            len_d   = len_clamped;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = (len_clamped != '0) ? ST_FILL : ST_IDLE;
        end else if (accept) begin
            hist_d  = hist_n;
            match_d = hit;
            if (hit && !ovl_q) begin
                // Non-overlap: a fresh len bits are needed before the next hit.
                fill_d  = '0;
                state_d = ST_FILL;
            end else begin
                fill_d  = fill_n;
                state_d = (fill_n == len_q) ? ST_RUN : ST_FILL;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            match_q <= match_d;
        end
    end

    seq_det_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (hit),
        .cnt_o (match_cnt)
    );

    assign match = match_q;
    assign state = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (MAX_LEN=8, CNT_W=4). Each driven
// cycle pushes its hand-computed expected outputs into a scoreboard queue;
// a monitor pops and compares on the following falling edge.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_we = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               din_valid = 1'b0;
    logic               din = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic [1:0]         state;

    typedef struct packed {
        logic        m;
        logic [3:0]  c;
        logic [1:0]  s;
        logic [15:0] id;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_pass  = 0;
    int   step_id = 0;

    seq_detector_param #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .din_valid   (din_valid),
        .din         (din),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_cnt   (match_cnt),
        .state       (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_total++;
            if (match !== mon_e.m || match_cnt !== mon_e.c || state !== mon_e.s) begin
                $display("FAIL step%0d: got match=%0b cnt=%0d state=%0d, expected match=%0b cnt=%0d state=%0d",
                         mon_e.id, match, match_cnt, state, mon_e.m, mon_e.c, mon_e.s);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic cyc(input logic rn, input logic we, input logic [7:0] p,
                       input logic [3:0] l, input logic o, input logic v,
                       input logic d, input logic c, input logic em,
                       input logic [3:0] ec, input logic [1:0] es);
        exp_t e;
        rst_n       = rn;
        cfg_we      = we;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        din_valid   = v;
        din         = d;
        cnt_clr     = c;
        @(posedge clk);
        e.m  = em;
        e.c  = ec;
        e.s  = es;
        e.id = 16'(step_id);
        step_id++;
        sb_q.push_back(e);
        #1;
    endtask

    task automatic bitv(input logic d, input logic em, input logic [3:0] ec, input logic [1:0] es);
        cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, d, 1'b0, em, ec, es);
    endtask

    task automatic gapc(input logic d, input logic [3:0] ec, input logic [1:0] es);
        cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, d, 1'b0, 1'b0, ec, es);
    endtask

    // Load with din_valid=1 so the discarded bit is exercised too.
    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                        input logic [3:0] ec, input logic [1:0] es);
        cyc(1'b1, 1'b1, p, l, o, 1'b1, 1'b1, 1'b0, 1'b0, ec, es);
    endtask

    initial begin
        logic [7:0] pv;
        pv = 8'hA5;

        // Reset, with a competing cfg_we that must lose.
        cyc(1'b0, 1'b1, 8'h05, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0);
        cyc(1'b0, 1'b1, 8'h05, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0);
        bitv(1'b1, 1'b0, 4'd0, 2'd0);
        bitv(1'b0, 1'b0, 4'd0, 2'd0);
        bitv(1'b1, 1'b0, 4'd0, 2'd0);
        bitv(1'b1, 1'b0, 4'd0, 2'd0);

        // Overlapping "101".
        load(8'h05, 4'd3, 1'b1, 4'd0, 2'd1);
        bitv(1'b1, 1'b0, 4'd0, 2'd1);
        bitv(1'b0, 1'b0, 4'd0, 2'd1);
        bitv(1'b1, 1'b1, 4'd1, 2'd2);
        bitv(1'b0, 1'b0, 4'd1, 2'd2);
        bitv(1'b1, 1'b1, 4'd2, 2'd2);

        // Non-overlapping "101": count carries over, single pulse.
        load(8'h05, 4'd3, 1'b0, 4'd2, 2'd1);
        bitv(1'b1, 1'b0, 4'd2, 2'd1);
        bitv(1'b0, 1'b0, 4'd2, 2'd1);
        bitv(1'b1, 1'b1, 4'd3, 2'd1);
        bitv(1'b0, 1'b0, 4'd3, 2'd1);
        bitv(1'b1, 1'b0, 4'd3, 2'd1);

        // Plain counter clear.
        cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 2'd1);

        // 0xA5 with a dead cycle (opposite din) after every bit.
        load(8'hA5, 4'd8, 1'b1, 4'd0, 2'd1);
        for (int i = 7; i >= 0; i--) begin
            if (i > 0) begin
                bitv(pv[i], 1'b0, 4'd0, 2'd1);
                gapc(~pv[i], 4'd0, 2'd1);
            end else begin
                bitv(pv[i], 1'b1, 4'd1, 2'd2);
                gapc(~pv[i], 4'd1, 2'd2);
            end
        end

        // Reload mid-pattern: a full 8 bits are needed again.
        load(8'hA5, 4'd8, 1'b1, 4'd1, 2'd1);
        for (int i = 7; i >= 4; i--) bitv(pv[i], 1'b0, 4'd1, 2'd1);
        load(8'hA5, 4'd8, 1'b1, 4'd1, 2'd1);
        for (int i = 7; i >= 1; i--) bitv(pv[i], 1'b0, 4'd1, 2'd1);
        bitv(pv[0], 1'b1, 4'd2, 2'd2);

        // Length 12 clamps to 8.
        load(8'hA5, 4'd12, 1'b1, 4'd2, 2'd1);
        for (int i = 7; i >= 1; i--) bitv(pv[i], 1'b0, 4'd2, 2'd1);
        bitv(pv[0], 1'b1, 4'd3, 2'd2);

        // Length 0 disables.
        load(8'h05, 4'd0, 1'b1, 4'd3, 2'd0);
        bitv(1'b1, 1'b0, 4'd3, 2'd0);
        bitv(1'b0, 1'b0, 4'd3, 2'd0);
        bitv(1'b1, 1'b0, 4'd3, 2'd0);

        // Length 1.
        load(8'h01, 4'd1, 1'b1, 4'd3, 2'd1);
        bitv(1'b1, 1'b1, 4'd4, 2'd2);
        bitv(1'b0, 1'b0, 4'd4, 2'd2);
        bitv(1'b1, 1'b1, 4'd5, 2'd2);

        // Clear coinciding with a hit: pulse still emitted, count zero.
        cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 2'd2);

        // Saturation at 15.
        for (int i = 1; i <= 20; i++) begin
            bitv(1'b1, 1'b1, (i > 15) ? 4'd15 : 4'(i), 2'd2);
        end

        // Reset mid-stream with a valid matching bit present.
        cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0);
        bitv(1'b1, 1'b0, 4'd0, 2'd0);

        din_valid = 1'b0;
        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left in scoreboard, expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Programmable serial bit-pattern detector, the parametrised successor to the team's fixed 4-state "101" detector. It sits on a serial bit stream with a qualifying valid strobe. It matches a runtime-loaded pattern of 1..MAX_LEN bits, in either overlapping or non-overlapping mode. It emits a registered one-cycle match pulse and keeps a saturating match count for host readback.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (2..32).
- LEN_W, $clog2(MAX_LEN+1): width of the length field.
- CNT_W, 16: width of the match counter.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_we  in  1  load cfg_* fields this cycle.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit 0 the last.
- cfg_len  in  LEN_W  pattern length; 0 disables, >MAX_LEN clamps to MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- din_valid  in  1  din is sampled only when high.
- din  in  1  serial data bit.
- cnt_clr  in  1  synchronous clear of match_cnt.
- match  out  1  one-cycle pulse, registered.
- match_cnt  out  CNT_W  saturating count of matches.
- state  out  2  current FSM state (IDLE=0, FILL=1, RUN=2), for debug.

## Operation
- Registers: hist[MAX_LEN-1:0] shift history, fill[LEN_W-1:0], pat, len, ovl, match, match_cnt, state.
- Reset: state=IDLE, hist=0, fill=0, pat=0, len=0, ovl=0, match=0, match_cnt=0.
- cfg_we: captures pattern, clamped length and overlap mode, and clears hist and fill.
  - Next state is FILL if the clamped length is nonzero, else IDLE.
  - match is 0 that cycle. din is ignored in the cfg_we cycle, even when din_valid=1.
  - match_cnt is not affected.
- IDLE: the block ignores din and keeps match=0.
- Accepted bit (din_valid=1, state≠IDLE, cfg_we=0):
  - hist_n = {hist[MAX_LEN-2:0], din}.
  - fill_n = min(fill+1, len).
  - hit = (fill_n==len) && (hist_n[len-1:0] == pat[len-1:0]); bits at and above len are masked.
- Compare and advance:
  - match <= hit; otherwise match <= 0.
  - On hit with ovl=0: fill <= 0, and state returns to FILL.
  - Otherwise fill <= fill_n, with state = RUN when fill_n==len, else FILL.
- match_cnt:
  - cnt_clr has priority: count <= 0, and a hit in the same cycle is not counted.
  - Else on hit: count increments, saturating at 2^CNT_W-1.
- din_valid=0: hist, fill, state hold; match <= 0.

## Timing
- Latency: match is high in the cycle after the clock edge that sampled the final pattern bit. match_cnt updates on that same edge.
- Back-to-back valid bits give a maximum of one match per accepted bit when ovl=1. When ovl=0, successive matches are at least len accepted bits apart.
- Gaps in din_valid do not break a partial match; only accepted bits count.
- len=1 is legal: every accepted bit equal to pat[0] matches.
- rst_n low mid-stream returns every output to its reset value on the next edge, regardless of other inputs. rst_n has priority over cfg_we.

## Structure
- Shared package seq_det_pkg holds the state encoding constants (ST_IDLE, ST_FILL, ST_RUN) and a masked-compare function (hist, pat, len) -> bit.
- Sub-module seq_det_counter implements the saturating counter with clear. The FSM, history register and compare stay in the top level.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles, then stream bits with no cfg_we -> match=0, match_cnt=0, state=IDLE throughout.
- Overlap "101": load pat=3'b101, len=3, ovl=1; stream 1,0,1,0,1 -> match pulses after the 3rd and 5th bits; match_cnt=2.
- Non-overlap "101": same stream with ovl=0 -> a single pulse after the 3rd bit; match_cnt=1; state returns to FILL after the hit.
- Valid gaps and reload:
  - Load pat=8'hA5, len=8. Send 10100101 with din_valid toggling 1,0 between bits -> exactly one pulse, one cycle after the last valid bit.
  - Then assert cfg_we mid-pattern with the same config -> history cleared; the next full 8 bits are required before a match.
- Clamp and disable, with MAX_LEN=8:
  - cfg_len=12 -> len reads as 8.
  - cfg_len=0 -> state=IDLE and no matches for any stream.
- Counter:
  - With CNT_W=4, generate 20 matches -> match_cnt saturates at 15.
  - cnt_clr on the same cycle as a hit -> match_cnt=0 and the match pulse is still emitted.
